// File: rtl/forward_pkg.sv
// Shared types for the forwarding scoreboard: register tag, in-flight entry and bubble.
package forward_pkg;

    localparam int FWD_TAG_W = 5;

    typedef logic [FWD_TAG_W-1:0] tag_t;

    typedef struct packed {
        logic valid;
        logic writes_rd;
        logic is_load;
        tag_t rd;
    } fwd_entry_t;

    localparam fwd_entry_t FWD_BUBBLE = '{valid: 1'b0, writes_rd: 1'b0, is_load: 1'b0, rd: '0};

endpackage

// File: rtl/forward_lookup.sv
// Youngest-match forwarding lookup for a single source operand; purely combinational.
module forward_lookup
    import forward_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int XLEN       = 32,
    parameter int LOAD_READY = 2
) (
    input  fwd_entry_t [DEPTH-1:0]      entries,
    input  logic [DEPTH*XLEN-1:0]       stage_value,
    input  tag_t                        tag,
    input  logic                        used,
    output logic                        hit,
    output logic                        need_stall,
    output logic [XLEN-1:0]             value
);

    logic found;

    always_comb begin
        hit        = 1'b0;
        need_stall = 1'b0;
        value      = '0;
        found      = 1'b0;
        if (used && (tag != '0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && entries[i].valid && entries[i].writes_rd && (entries[i].rd == tag)) begin
                    found = 1'b1;
                    // a load that has not reached LOAD_READY has no data yet
                    if (entries[i].is_load && (i < LOAD_READY)) begin
                        need_stall = 1'b1;
                    end else begin
                        hit   = 1'b1;
                        value = stage_value[i*XLEN +: XLEN];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// In-flight destination tag tracker with per-operand forwarding, load-use stall
// and a saturating stall-cycle counter.
module forward_scoreboard
    import forward_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int XLEN       = 32,
    parameter int TAG_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_READY = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic                        issue_writes_rd,
    input  logic                        issue_is_load,
    input  logic [TAG_W-1:0]            issue_rd,
    input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
    input  logic [NUM_SRC-1:0]          src_used,
    input  logic [DEPTH*XLEN-1:0]       stage_value,
    input  logic                        flush,
    output logic                        stall,
    output logic [NUM_SRC-1:0]          fwd_hit,
    output logic [NUM_SRC*XLEN-1:0]     fwd_value,
    output logic [31:0]                 stall_cycles
);

    if (DEPTH < 1)              begin : g_bad_depth   $error("DEPTH must be >= 1");          end
    if (LOAD_READY >= DEPTH)    begin : g_bad_ready   $error("LOAD_READY must be < DEPTH");  end
    if (NUM_SRC < 1)            begin : g_bad_nsrc    $error("NUM_SRC must be >= 1");        end
    if (TAG_W != FWD_TAG_W)     begin : g_bad_tag     $error("TAG_W must match tag_t");      end

    fwd_entry_t [DEPTH-1:0]    entries;
    logic [NUM_SRC-1:0]        raw_hit;
    logic [NUM_SRC-1:0]        need_stall;
    logic [NUM_SRC*XLEN-1:0]   raw_value;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        forward_lookup #(
            .DEPTH      (DEPTH),
            .XLEN       (XLEN),
            .LOAD_READY (LOAD_READY)
        ) u_lookup (
            .entries     (entries),
            .stage_value (stage_value),
            .tag         (src_tag[k*TAG_W +: TAG_W]),
            .used        (src_used[k]),
            .hit         (raw_hit[k]),
            .need_stall  (need_stall[k]),
            .value       (raw_value[k*XLEN +: XLEN])
        );
    end

    always_comb begin
        stall     = issue_valid & ~flush & ~reset & (|need_stall);
        fwd_hit   = reset ? '0 : raw_hit;
        fwd_value = reset ? '0 : raw_value;
    end

    // older entries advance unconditionally; a stall only injects a bubble at e[0]
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= FWD_BUBBLE;
            end
            stall_cycles <= '0;
        end else begin
            if (issue_valid && !flush && !stall) begin
                entries[0] <= '{valid: 1'b1, writes_rd: issue_writes_rd,
                                is_load: issue_is_load, rd: issue_rd};
            end else begin
                entries[0] <= FWD_BUBBLE;
            end
            for (int i = 1; i < DEPTH; i++) begin
                entries[i] <= entries[i-1];
            end
            if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule
